// File: rtl/except_ctrl.sv
// Exception/interrupt controller between MEM and cp0_reg: picks one cause by
// fixed priority, presents the cp0 update for one cycle, then sequences flush and redirect.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic [31:0] bad_vaddr_o,
    output logic        exc_delayslot_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        busy_o,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [31:0] target;
    logic        int_pend;
    logic        take;
    logic [31:0] code;
    logic [31:0] bva;

    assign int_pend = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];
    assign take     = mem_valid_i & ~mem_stall_i & (state == S_IDLE) & (int_pend | (|exc_flags_i));

    // Flag bits are already laid out in priority order, bit0 highest after the interrupt.
    always_comb begin
        code = 32'd0;
        bva  = 32'd0;
        if (int_pend)            code = 32'd1;
        else if (exc_flags_i[0]) begin code = 32'd4; bva = mem_pc_i; end
        else if (exc_flags_i[1]) code = 32'd10;
        else if (exc_flags_i[2]) code = 32'd12;
        else if (exc_flags_i[3]) code = 32'd13;
        else if (exc_flags_i[4]) code = 32'd8;
        else if (exc_flags_i[5]) code = 32'd9;
        else if (exc_flags_i[6]) begin code = 32'd4; bva = mem_addr_i; end
        else if (exc_flags_i[7]) begin code = 32'd5; bva = mem_addr_i; end
        else if (exc_flags_i[8]) code = 32'd14;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excepttype_o    <= 32'd0;
            exc_pc_o        <= 32'd0;
            bad_vaddr_o     <= 32'd0;
            exc_delayslot_o <= 1'b0;
        end else if (take) begin
            excepttype_o    <= code;
            exc_pc_o        <= mem_pc_i;
            bad_vaddr_o     <= bva;
            exc_delayslot_o <= in_delayslot_i;
        end else begin
            excepttype_o    <= 32'd0;
            exc_pc_o        <= 32'd0;
            bad_vaddr_o     <= 32'd0;
            exc_delayslot_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 3'd0;
            target <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state  <= S_FLUSH;
                        cnt    <= 3'(FLUSH_CYCLES);
                        target <= (code == 32'd14) ? epc_i : EXC_VECTOR;
                    end
                end
                S_FLUSH: begin
                    if (cnt <= 3'd1) state <= S_REDIRECT;
                    else             cnt   <= cnt - 3'd1;
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Redirect handshake: valid/pc stay stable until the cycle ready is seen high.
    assign flush_o          = (state == S_FLUSH);
    assign redirect_valid_o = (state == S_REDIRECT);
    assign redirect_pc_o    = (state == S_REDIRECT) ? target : 32'd0;
    assign busy_o           = (state != S_IDLE);
    assign state_dbg        = state;

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception/interrupt controller sitting between the MEM stage and cp0_reg.
- Each cycle it collects the MEM-stage instruction's exception flags and the pending-interrupt condition, and picks one cause by fixed priority.
- It drives cp0_reg's excepttype/pc/bad_vaddr/delayslot inputs for exactly one cycle, then sequences the pipeline flush and the fetch redirect (exception vector or EPC for ERET) through a handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions and interrupts.
- FLUSH_CYCLES, 2, number of cycles flush_o is held after an exception is taken (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_stall_i  in  1  MEM stage stalled this cycle; nothing commits
- exc_flags_i  in  9  {eret, ades, adel_d, brk, sys, trap, ov, ri, adel_if}, bit0 = adel_if
- mem_pc_i  in  32  PC of the MEM-stage instruction
- mem_addr_i  in  32  data address of the load/store
- in_delayslot_i  in  1  instruction is in a delay slot
- status_i  in  32  CP0 Status from cp0_reg
- cause_i  in  32  CP0 Cause from cp0_reg
- epc_i  in  32  CP0 EPC from cp0_reg (already bypassed)
- excepttype_o  out  32  exception code to cp0_reg
- exc_pc_o  out  32  PC to cp0_reg
- bad_vaddr_o  out  32  BadVAddr to cp0_reg
- exc_delayslot_o  out  1  delay-slot flag to cp0_reg
- flush_o  out  1  flush IF..MEM
- redirect_valid_o  out  1  new PC valid to fetch
- redirect_pc_o  out  32  new PC
- redirect_ready_i  in  1  fetch accepts redirect
- busy_o  out  1  controller not IDLE

Behaviour:
- Interrupt pending: int_pend = |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
- Commit: take = mem_valid_i & ~mem_stall_i & (state==IDLE) & (int_pend | |exc_flags_i).
- Priority, highest first, with code:
  - int_pend -> 1
  - adel_if -> 4
  - ri -> 10
  - ov -> 12
  - trap -> 13
  - sys -> 8
  - brk -> 9
  - adel_d -> 4
  - ades -> 5
  - eret -> 14
- Lower-priority flags are ignored when a higher one is present.
- BadVAddr source: mem_pc_i for adel_if, mem_addr_i for adel_d/ades, 0 otherwise.
- Registered outputs: excepttype_o, exc_pc_o, bad_vaddr_o and exc_delayslot_o are registered. They are nonzero for exactly one cycle: the cycle after take. In every other cycle excepttype_o=0 and the other three hold 0.
- FSM states: IDLE, FLUSH, REDIRECT.
  - IDLE -> FLUSH on take. Load the flush counter with FLUSH_CYCLES. Latch the target: EXC_VECTOR, or epc_i if the code is 14.
  - FLUSH: flush_o=1 and the counter decrements each cycle. When the counter reaches 1, go to REDIRECT.
  - REDIRECT: redirect_valid_o=1 and redirect_pc_o=target, both held stable. When redirect_ready_i=1, go to IDLE in the same edge.
  - redirect_valid_o and redirect_pc_o are 0 outside REDIRECT.
- busy_o = (state != IDLE).
- While busy, all flags and int_pend are ignored. An interrupt that is still pending is taken later, after return to IDLE.
- The flush begins in the same cycle the cp0 update is presented.
- If mem_stall_i=1 while exceptions are present, nothing is taken; evaluation is retried the next cycle.
- ERET inside a delay slot: the code-14 path is still taken; exc_delayslot_o mirrors the input.
- Reset (asynchronous, any state, including mid-flush or mid-redirect): state=IDLE and all outputs are 0. redirect_valid_o drops immediately.
- FLUSH_CYCLES=1: FLUSH lasts exactly one cycle.

Test Plan:
- Single syscall at PC 0xBFC00100, not in a delay slot:
  - cycle+1: excepttype_o=8, exc_pc_o=0xBFC00100, exc_delayslot_o=0.
  - flush_o high for 2 cycles.
  - redirect_pc_o=0xBFC00380 until redirect_ready_i.
- Simultaneous flags ov+sys+ades with mem_addr_i=0x80000003: excepttype_o=12 and bad_vaddr_o=0. A repeat with only ades gives code 5 and bad_vaddr_o=0x80000003.
- Interrupt with status=0x00000401, cause[10]=1, syscall flag also set: code 1. A repeat with status[1]=1 gives code 8.
- ERET with epc_i=0xBFC00200: code 14, redirect_pc_o=0xBFC00200. Hold redirect_ready_i=0 for 5 cycles: redirect stays valid and stable, busy_o=1, and a new ri flag is ignored.
- mem_stall_i=1 for 3 cycles with brk set: no output change. On the first unstalled cycle, code 9 appears on the next edge.
- Assert rst asynchronously during FLUSH: flush_o, busy_o and redirect_valid_o go to 0 before the next clock edge. After release, a new adel_if is taken normally.
